alu_chain_sequencer: RTL and testbench

//  Multi-cycle controller that runs an NWORDS*WIDTH-bit operation through one WIDTH-bit combinational ALU slice.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq_word_path.sv | 44 ++++
 rtl/alu_chain_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_chain_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the word-serial ALU chain sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ARITH = 1'b1;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NWORDS = 4;

    // Word index width; a single-word build still needs a 1-bit index.
    function automatic int idx_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/alu_seq_word_path.sv
// Word-select mux for the latched A/B operands and the result word
// write-back register. Words are addressed by the sequencer's index.
module alu_seq_word_path
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NWORDS = DEF_NWORDS,
    parameter int IDX_W  = idx_width(DEF_NWORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WIDTH*NWORDS-1:0] a,
    input  logic [WIDTH*NWORDS-1:0] b,
    input  logic [WIDTH-1:0]        y,
    output logic [WIDTH-1:0]        word_a,
    output logic [WIDTH-1:0]        word_b,
    output logic [WIDTH*NWORDS-1:0] result
);

    int base;

    // Present the current operand words only while a pass is running.
    always_comb begin
        base   = int'(idx) * WIDTH;
        word_a = '0;
        word_b = '0;
        if (run) begin
            word_a = a[base +: WIDTH];
            word_b = b[base +: WIDTH];
        end
    end

    // Capture the ALU output into the result word selected by the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else if (run) begin
            result[base +: WIDTH] <= y;
        end
    end

endmodule

// File: rtl/alu_chain_sequencer.sv
// Runs a WIDTH*NWORDS-bit operation through one WIDTH-bit combinational ALU,
// one word per cycle, LSW first, chaining carry through a register.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the rsp_zero output.
module alu_chain_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NWORDS = DEF_NWORDS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WIDTH*NWORDS-1:0] req_a,
    input  logic [WIDTH*NWORDS-1:0] req_b,
    input  logic                    req_cin,
    input  logic                    req_mode,
    input  logic                    req_opsel,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic                    alu_cin,
    output logic                    alu_mode,
    output logic                    alu_opsel,
    input  logic [WIDTH-1:0]        alu_y,
    input  logic                    alu_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH*NWORDS-1:0] rsp_result,
    output logic                    rsp_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic                    rsp_zero,
`endif
    output logic                    rsp_oflag
);

    localparam int               IDX_W = idx_width(NWORDS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NWORDS - 1);

    seq_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic                    carry_q;
    logic                    cin_q;
    logic                    mode_q;
    logic                    opsel_q;
    logic [WIDTH*NWORDS-1:0] a_q;
    logic [WIDTH*NWORDS-1:0] b_q;
    logic                    run;

    assign run       = (state == RUN);
    assign alu_mode  = mode_q;
    assign alu_opsel = opsel_q;

    // Word 0 takes the request carry-in, later words the registered carry;
    // logic mode never feeds a carry into the ALU.
    always_comb begin
        alu_cin = 1'b0;
        if (run && mode_q == MODE_ARITH) begin
            alu_cin = (idx == '0) ? cin_q : carry_q;
        end
    end

    alu_seq_word_path #(
        .WIDTH  (WIDTH),
        .NWORDS (NWORDS),
        .IDX_W  (IDX_W)
    ) u_word_path (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .idx    (idx),
        .a      (a_q),
        .b      (b_q),
        .y      (alu_y),
        .word_a (alu_a),
        .word_b (alu_b),
        .result (rsp_result)
    );

    // Sequencer FSM: accept, step through the words, then hold the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_cout  <= 1'b0;
            rsp_oflag <= 1'b0;
            carry_q   <= 1'b0;
            idx       <= '0;
            mode_q    <= MODE_LOGIC;
            opsel_q   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            rsp_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q       <= req_a;
                        b_q       <= req_b;
                        cin_q     <= req_cin;
                        mode_q    <= req_mode;
                        opsel_q   <= req_opsel;
                        idx       <= '0;
                        carry_q   <= 1'b0;
                        req_ready <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        rsp_zero  <= 1'b1;
`endif
                        state     <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    rsp_zero <= rsp_zero & (alu_y == '0);
`endif
                    if (idx == LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_cout  <= mode_q & alu_cout;
                        rsp_oflag <= mode_q & opsel_q & alu_cout;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_chain_sequencer.sv
// Self-checking bench for alu_chain_sequencer (WIDTH=8, NWORDS=4) with a
// behavioural ALU and a whole-operand arithmetic reference model.
module tb_alu_chain_sequencer;

    localparam int W  = 8;
    localparam int NW = 4;
    localparam int FW = W * NW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [FW-1:0] req_a = '0;
    logic [FW-1:0] req_b = '0;
    logic          req_cin = 1'b0;
    logic          req_mode = 1'b0;
    logic          req_opsel = 1'b0;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_cin;
    logic          alu_mode;
    logic          alu_opsel;
    logic [W-1:0]  alu_y;
    logic          alu_cout;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [FW-1:0] rsp_result;
    logic          rsp_cout;
    logic          rsp_oflag;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic          rsp_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_chain_sequencer #(.WIDTH(W), .NWORDS(NW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .req_mode   (req_mode),
        .req_opsel  (req_opsel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_mode   (alu_mode),
        .alu_opsel  (alu_opsel),
        .alu_y      (alu_y),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .rsp_oflag  (rsp_oflag)
    );

    // Behavioural ALU slice: add with carry in arithmetic mode, AND in logic mode.
    always_comb begin
        if (alu_mode) begin
            {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
        end else begin
            alu_y    = alu_a & alu_b;
            alu_cout = 1'b0;
        end
    end

    // Whole-operand reference: the answer the chained passes must reproduce.
    task automatic model(input logic [FW-1:0] a, input logic [FW-1:0] b,
                         input logic cin, input logic mode, input logic opsel,
                         output logic [FW-1:0] res, output logic cout,
                         output logic oflag, output logic zero);
        logic [FW:0] s;
        if (mode) begin
            s    = {1'b0, a} + {1'b0, b} + {{FW{1'b0}}, cin};
            res  = s[FW-1:0];
            cout = s[FW];
        end else begin
            res  = a & b;
            cout = 1'b0;
        end
        oflag = mode & opsel & cout;
        zero  = (res == '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one request from IDLE and wait (bounded) for rsp_valid.
    // lat counts posedges from the accepting edge up to the one raising rsp_valid.
    task automatic do_op(input logic [FW-1:0] a, input logic [FW-1:0] b,
                         input logic cin, input logic mode, input logic opsel,
                         output int lat, output logic cin_seen);
        @(negedge clk);
        req_a = a; req_b = b; req_cin = cin; req_mode = mode; req_opsel = opsel;
        req_valid = 1'b1;
        cin_seen = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (alu_cin !== 1'b0) cin_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_result !== '0) begin n_fail++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
        n_checks++; if (rsp_cout !== 1'b0 || rsp_oflag !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", rsp_cout, rsp_oflag); end
        n_checks++; if (alu_a !== '0 || alu_b !== '0 || alu_cin !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ops got=%h/%h/%b exp=0/0/0", alu_a, alu_b, alu_cin); end
        n_checks++; if (alu_mode !== 1'b0 || alu_opsel !== 1'b0) begin n_fail++; $display("FAIL reset_alu_mode got=%b%b exp=00", alu_mode, alu_opsel); end
    endtask

    task automatic test_arith_basic();
        int lat; logic cs; logic [FW-1:0] er; logic ec, eo, ez;
        model(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 1'b0, er, ec, eo, ez);
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 1'b0, lat, cs);
        n_checks++; if (lat !== 5 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL arith_latency got=%0d valid=%b exp=5", lat, rsp_valid); end
        n_checks++; if (rsp_result !== er) begin n_fail++; $display("FAIL arith_result got=%h exp=%h", rsp_result, er); end
        n_checks++; if (rsp_cout !== ec || rsp_oflag !== eo) begin n_fail++; $display("FAIL arith_flags got=%b%b exp=%b%b", rsp_cout, rsp_oflag, ec, eo); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL arith_ready_done got=%b exp=0", req_ready); end
        consume();
    endtask

    task automatic test_carry_chain();
        int lat; logic cs; logic [FW-1:0] er; logic ec, eo, ez;
        for (int k = 0; k < 2; k++) begin
            logic op;
            op = (k == 0);
            model(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, op, er, ec, eo, ez);
            do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, op, lat, cs);
            n_checks++; if (rsp_result !== er) begin n_fail++; $display("FAIL chain_result opsel=%b got=%h exp=%h", op, rsp_result, er); end
            n_checks++; if (rsp_cout !== ec || rsp_oflag !== eo) begin n_fail++; $display("FAIL chain_flags opsel=%b got=%b%b exp=%b%b", op, rsp_cout, rsp_oflag, ec, eo); end
            consume();
        end
    endtask

    task automatic test_logic();
        int lat; logic cs; logic [FW-1:0] er; logic ec, eo, ez;
        model(32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 1'b1, er, ec, eo, ez);
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 1'b1, lat, cs);
        n_checks++; if (rsp_result !== er) begin n_fail++; $display("FAIL logic_result got=%h exp=%h", rsp_result, er); end
        n_checks++; if (cs !== 1'b0) begin n_fail++; $display("FAIL logic_alu_cin got=%b exp=0", cs); end
        n_checks++; if (rsp_cout !== 1'b0 || rsp_oflag !== 1'b0) begin n_fail++; $display("FAIL logic_flags got=%b%b exp=00", rsp_cout, rsp_oflag); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat; logic cs; logic [FW-1:0] er; logic ec, eo, ez;
        model(32'h12345678, 32'hF0000009, 1'b1, 1'b1, 1'b1, er, ec, eo, ez);
        do_op(32'h12345678, 32'hF0000009, 1'b1, 1'b1, 1'b1, lat, cs);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== er || rsp_cout !== ec || rsp_oflag !== eo) begin
                n_fail++;
                $display("FAIL stall_hold c=%0d got v=%b r=%b %h %b%b exp v=1 r=0 %h %b%b", c, rsp_valid, req_ready, rsp_result, rsp_cout, rsp_oflag, er, ec, eo);
            end
        end
        consume();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got v=%b r=%b exp v=0 r=1", rsp_valid, req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single_rsp c=%0d got=%b exp=0", c, rsp_valid); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        @(negedge clk);
        req_a = 32'hAAAA5555; req_b = 32'h0F0F0F0F; req_cin = 1'b1; req_mode = 1'b1; req_opsel = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got r=%b v=%b exp r=1 v=0", req_ready, rsp_valid); end
        n_checks++; if (rsp_result !== '0 || alu_mode !== 1'b0 || alu_opsel !== 1'b0) begin n_fail++; $display("FAIL midrun_clear got %h %b%b exp 0 00", rsp_result, alu_mode, alu_opsel); end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrun_dropped got rsp=%b exp=0", seen); end
    endtask

    task automatic test_random();
        int lat; logic cs; logic [FW-1:0] a, b, er; logic ci, md, op, ec, eo, ez;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom;
            if (i % 5 == 0) b = ~a;
            ci = 1'($urandom_range(0, 1)); md = 1'($urandom_range(0, 1)); op = 1'($urandom_range(0, 1));
            model(a, b, ci, md, op, er, ec, eo, ez);
            do_op(a, b, ci, md, op, lat, cs);
            n_checks++;
            if (lat !== 5 || rsp_result !== er || rsp_cout !== ec || rsp_oflag !== eo) begin
                n_fail++;
                $display("FAIL random_op i=%0d got lat=%0d %h %b%b exp lat=5 %h %b%b", i, lat, rsp_result, rsp_cout, rsp_oflag, er, ec, eo);
            end
            for (int s = $urandom_range(0, 2); s > 0; s--) @(posedge clk);
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] qa[$], qb[$];
        logic qc[$], qm[$], qo[$];
        logic [FW-1:0] er; logic ec, eo, ez, nxt;
        int got, prev_t;
        got = 0; prev_t = -1; nxt = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom_range(0, 1));
        req_mode = 1'($urandom_range(0, 1)); req_opsel = 1'($urandom_range(0, 1));
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            @(negedge clk);
            if (rsp_valid && qa.size() > 0) begin
                model(qa.pop_front(), qb.pop_front(), qc.pop_front(), qm.pop_front(), qo.pop_front(), er, ec, eo, ez);
                n_checks++; if (rsp_result !== er || rsp_cout !== ec || rsp_oflag !== eo) begin n_fail++; $display("FAIL b2b_result n=%0d got %h %b%b exp %h %b%b", got, rsp_result, rsp_cout, rsp_oflag, er, ec, eo); end
                if (prev_t >= 0) begin
                    n_checks++; if (cyc - prev_t !== NW + 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - prev_t, NW + 2); end
                end
                prev_t = cyc;
                got++;
            end
            nxt = req_valid && req_ready;
            if (nxt) begin
                qa.push_back(req_a); qb.push_back(req_b); qc.push_back(req_cin); qm.push_back(req_mode); qo.push_back(req_opsel);
            end
            @(posedge clk); #1;
            if (nxt) begin
                req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom_range(0, 1));
                req_mode = 1'($urandom_range(0, 1)); req_opsel = 1'($urandom_range(0, 1));
            end
        end
        n_checks++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", got); end
        apply_reset();
    endtask

`ifdef ALU_SEQ_ZERO_FLAG_EN
    task automatic test_zero_flag();
        int lat; logic cs; logic [FW-1:0] er; logic ec, eo, ez;
        model(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, er, ec, eo, ez);
        do_op(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, lat, cs);
        n_checks++; if (rsp_zero !== ez) begin n_fail++; $display("FAIL zero_all got=%b exp=%b", rsp_zero, ez); end
        consume();
        model(32'h01000000, 32'h0, 1'b0, 1'b1, 1'b0, er, ec, eo, ez);
        do_op(32'h01000000, 32'h0, 1'b0, 1'b1, 1'b0, lat, cs);
        n_checks++; if (rsp_zero !== ez) begin n_fail++; $display("FAIL zero_msw got=%b exp=%b", rsp_zero, ez); end
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_arith_basic();
        test_carry_chain();
        test_logic();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
`ifdef ALU_SEQ_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
